// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V fetch front end; owns the fetch PC, tracks in-order imem reads, buffers 2 instructions for decode.
// Latency: request valid is combinational from queue room (incl. same-cycle decode pop); a response reaches Instr_Valid 1 cycle later.
// Backpressure: requests stop once buffered + in-flight reaches 2; an unaccepted request is held stable until accepted or redirected.
//
// Ports:
//   Clk_Core / Rst_Core                 clock, async active-high reset
//   Run                                 fetch enable (gates new requests only)
//   Redirect_Valid / Redirect_Pc        branch/jump redirect, word-aligned target
//   Program_Count                       PC of the next request to issue
//   Imem_Req_Valid/Ready/Addr           instruction memory read request channel
//   Imem_Rsp_Valid / Imem_Rsp_Data      in-order read responses, no backpressure
//   Instr_Valid/Ready, Instr_Data/Pc    decode-side handshake, queue head

module instr_fetch_unit #(
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Run,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Pc,
  output logic [DWIDTH-1:0] Program_Count,
  output logic              Imem_Req_Valid,
  input  logic              Imem_Req_Ready,
  output logic [DWIDTH-1:0] Imem_Req_Addr,
  input  logic              Imem_Rsp_Valid,
  input  logic [31:0]       Imem_Rsp_Data,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [31:0]       Instr_Data,
  output logic [DWIDTH-1:0] Instr_Pc
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              hold_q, hold_d;      // request raised last cycle but not accepted
  logic [1:0]        total_q, total_d;    // accepted, response not yet seen
  logic [1:0]        disc_q, disc_d;      // part of total whose data must be dropped

  // Pending-PC queue: PCs of live (non-discarded) in-flight requests, head in slot 0.
  logic [DWIDTH-1:0] ppc0_q, ppc0_d, ppc1_q, ppc1_d;
  logic [1:0]        ppc_cnt_q, ppc_cnt_d;

  // Instruction queue: {pc, data} pairs for decode, head in slot 0.
  logic [DWIDTH-1:0] iq_pc0_q, iq_pc0_d, iq_pc1_q, iq_pc1_d;
  logic [31:0]       iq_dat0_q, iq_dat0_d, iq_dat1_q, iq_dat1_d;
  logic [1:0]        occ_q, occ_d;

  // ---------------------------------------------------------------------------
  // Handshake events
  // ---------------------------------------------------------------------------
  logic       pop;
  logic       accept;
  logic       rsp_keep;
  logic       rsp_old;
  logic [2:0] load;
  logic       room;
  logic       redirect_pc_unused;

  // Low address bits of the target are forced to zero below.
  assign redirect_pc_unused = ^Redirect_Pc[1:0];

  assign pop = Instr_Valid && Instr_Ready;

  // occ + total never exceeds 2 and pop implies occ >= 1, so this cannot underflow.
  assign load = {1'b0, occ_q} + {1'b0, total_q} - {2'b00, pop};
  assign room = (load < 3'd2);

  // Once raised, a request stays up regardless of Run; only a redirect withdraws it.
  // Reset gating keeps the output at 0 while Rst_Core is high even if Run is set.
  assign Imem_Req_Valid = !Rst_Core && !Redirect_Valid && (hold_q || (Run && room));
  assign accept         = Imem_Req_Valid && Imem_Req_Ready;

  // A response is either for a squashed request (dropped) or for the pending-PC head.
  // A response in a redirect cycle is dropped too; discard is reloaded to exclude it.
  assign rsp_old  = Imem_Rsp_Valid && (disc_q != 2'd0);
  assign rsp_keep = Imem_Rsp_Valid && (disc_q == 2'd0) && !Redirect_Valid;

  // ---------------------------------------------------------------------------
  // PC, request hold, counters
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    hold_d  = Imem_Req_Valid && !Imem_Req_Ready;
    total_d = total_q + {1'b0, accept} - {1'b0, Imem_Rsp_Valid};
    disc_d  = disc_q;

    if (Redirect_Valid) begin
      pc_d   = {Redirect_Pc[DWIDTH-1:2], 2'b00};
      disc_d = total_q - {1'b0, Imem_Rsp_Valid};
    end else begin
      if (accept) begin
        pc_d = pc_q + DWIDTH'(4);
      end
      if (rsp_old) begin
        disc_d = disc_q - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-PC queue: push on accept, pop on a kept response
  // ---------------------------------------------------------------------------
  always_comb begin
    ppc0_d    = ppc0_q;
    ppc1_d    = ppc1_q;
    ppc_cnt_d = ppc_cnt_q;

    if (Redirect_Valid) begin
      ppc_cnt_d = 2'd0;
    end else begin
      case ({accept, rsp_keep})
        2'b10: begin
          if (ppc_cnt_q == 2'd0) ppc0_d = pc_q;
          else                   ppc1_d = pc_q;
          ppc_cnt_d = ppc_cnt_q + 2'd1;
        end
        2'b01: begin
          ppc0_d    = ppc1_q;
          ppc_cnt_d = ppc_cnt_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged: the head leaves while the new PC enters behind it.
          if (ppc_cnt_q == 2'd1) begin
            ppc0_d = pc_q;
          end else begin
            ppc0_d = ppc1_q;
            ppc1_d = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction queue: push kept responses, pop on decode handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    iq_pc0_d  = iq_pc0_q;
    iq_pc1_d  = iq_pc1_q;
    iq_dat0_d = iq_dat0_q;
    iq_dat1_d = iq_dat1_q;
    occ_d     = occ_q;

    if (Redirect_Valid) begin
      // A decode handshake in this cycle still completes; decode squashes it.
      occ_d = 2'd0;
    end else begin
      case ({rsp_keep, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            iq_pc0_d  = ppc0_q;
            iq_dat0_d = Imem_Rsp_Data;
          end else begin
            iq_pc1_d  = ppc0_q;
            iq_dat1_d = Imem_Rsp_Data;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          iq_pc0_d  = iq_pc1_q;
          iq_dat0_d = iq_dat1_q;
          occ_d     = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            iq_pc0_d  = ppc0_q;
            iq_dat0_d = Imem_Rsp_Data;
          end else begin
            iq_pc0_d  = iq_pc1_q;
            iq_dat0_d = iq_dat1_q;
            iq_pc1_d  = ppc0_q;
            iq_dat1_d = Imem_Rsp_Data;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      pc_q      <= RESET_PC;
      hold_q    <= 1'b0;
      total_q   <= 2'd0;
      disc_q    <= 2'd0;
      ppc0_q    <= '0;
      ppc1_q    <= '0;
      ppc_cnt_q <= 2'd0;
      iq_pc0_q  <= '0;
      iq_pc1_q  <= '0;
      iq_dat0_q <= '0;
      iq_dat1_q <= '0;
      occ_q     <= 2'd0;
    end else begin
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      total_q   <= total_d;
      disc_q    <= disc_d;
      ppc0_q    <= ppc0_d;
      ppc1_q    <= ppc1_d;
      ppc_cnt_q <= ppc_cnt_d;
      iq_pc0_q  <= iq_pc0_d;
      iq_pc1_q  <= iq_pc1_d;
      iq_dat0_q <= iq_dat0_d;
      iq_dat1_q <= iq_dat1_d;
      occ_q     <= occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Program_Count = pc_q;
  assign Imem_Req_Addr = pc_q;
  assign Instr_Valid   = (occ_q != 2'd0);
  assign Instr_Data    = iq_dat0_q;
  assign Instr_Pc      = iq_pc0_q;

endmodule
